// File: rtl/rst_mon_if.sv
// Observed-reset input and status outputs of the reset monitor.
// master: drives the observed reset and reads status; slave: the monitor itself.
interface rst_mon_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             obs_rst_ni;
  logic [CNT_W-1:0] rst_len_o;
  logic [CNT_W-1:0] run_cyc_o;
  logic [7:0]       rst_cnt_o;
  logic             rel_pulse_o;
  logic             in_rst_o;
  logic             err_short_o;
  logic             err_timeout_o;

  modport master (
    output obs_rst_ni,
    input  rst_len_o,
    input  run_cyc_o,
    input  rst_cnt_o,
    input  rel_pulse_o,
    input  in_rst_o,
    input  err_short_o,
    input  err_timeout_o
  );

  modport slave (
    input  obs_rst_ni,
    output rst_len_o,
    output run_cyc_o,
    output rst_cnt_o,
    output rel_pulse_o,
    output in_rst_o,
    output err_short_o,
    output err_timeout_o
  );
endinterface

// File: rtl/rst_mon.sv
// Reset monitor: measures each assertion of a foreign reset and flags short assertions.
// Define RST_MON_TIMEOUT_EN to also flag assertions longer than TIMEOUT_CYCLES.
module rst_mon #(
  parameter int unsigned MIN_RST_CYCLES = 5,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic      clk_i,
  input logic      rst_ni,
  rst_mon_if.slave mon_if
);

  typedef enum logic [1:0] {StInRst, StRun, StErr} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, obs_s;
  logic [CNT_W-1:0] len_cnt_q, len_cnt_d;
  logic [CNT_W-1:0] rst_len_q, rst_len_d;
  logic [CNT_W-1:0] run_cyc_q, run_cyc_d;
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic             rel_pulse_q, rel_pulse_d;
  logic             in_rst_q, in_rst_d;
  logic             err_short_q, err_short_d;
  logic [31:0]      len_ext;
  logic             release_ok, timeout_hit;

  // Synchronizer resets to 0 so the observed reset reads as asserted until seen released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= mon_if.obs_rst_ni;
      sync2_q <= sync1_q;
    end
  end

  assign obs_s      = sync2_q;
  assign len_ext    = 32'(len_cnt_q);
  assign release_ok = (len_ext >= MIN_RST_CYCLES);

`ifdef RST_MON_TIMEOUT_EN
  logic err_timeout_q, err_timeout_d;

  assign timeout_hit = (len_ext >= TIMEOUT_CYCLES);

  always_comb begin
    err_timeout_d = err_timeout_q | ((state_q == StInRst) && timeout_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= err_timeout_d;
    end
  end

  assign mon_if.err_timeout_o = err_timeout_q;
`else
  assign timeout_hit          = 1'b0;
  assign mon_if.err_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInRst: begin
        if (obs_s) begin
          state_d = release_ok ? StRun : StErr;
        end
        // A timeout wins over a release seen on the same edge.
        if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StRun: begin
        if (!obs_s) begin
          state_d = StInRst;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StInRst;
    endcase
  end

  always_comb begin
    len_cnt_d   = len_cnt_q;
    rst_len_d   = rst_len_q;
    run_cyc_d   = run_cyc_q;
    rst_cnt_d   = rst_cnt_q;
    rel_pulse_d = 1'b0;
    err_short_d = err_short_q;
    in_rst_d    = (state_d == StInRst);
    case (state_q)
      StInRst: begin
        if (state_d == StRun) begin
          rst_len_d   = len_cnt_q;
          rst_cnt_d   = (rst_cnt_q == 8'hFF) ? rst_cnt_q : rst_cnt_q + 8'd1;
          run_cyc_d   = '0;
          rel_pulse_d = 1'b1;
        end else if (state_d == StErr) begin
          if (!timeout_hit) begin
            rst_len_d   = len_cnt_q;
            err_short_d = 1'b1;
          end
        end else if (len_cnt_q != '1) begin
          len_cnt_d = len_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (obs_s) begin
          if (run_cyc_q != '1) begin
            run_cyc_d = run_cyc_q + 1'b1;
          end
        end else begin
          // The edge that first sees the assertion counts as its first cycle.
          len_cnt_d = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_cnt_q   <= '0;
      rst_len_q   <= '0;
      run_cyc_q   <= '0;
      rst_cnt_q   <= '0;
      rel_pulse_q <= 1'b0;
      in_rst_q    <= 1'b1;
      err_short_q <= 1'b0;
    end else begin
      len_cnt_q   <= len_cnt_d;
      rst_len_q   <= rst_len_d;
      run_cyc_q   <= run_cyc_d;
      rst_cnt_q   <= rst_cnt_d;
      rel_pulse_q <= rel_pulse_d;
      in_rst_q    <= in_rst_d;
      err_short_q <= err_short_d;
    end
  end

  assign mon_if.rst_len_o   = rst_len_q;
  assign mon_if.run_cyc_o   = run_cyc_q;
  assign mon_if.rst_cnt_o   = rst_cnt_q;
  assign mon_if.rel_pulse_o = rel_pulse_q;
  assign mon_if.in_rst_o    = in_rst_q;
  assign mon_if.err_short_o = err_short_q;

endmodule

// File: tb/tb_rst_mon.sv
// Bench for rst_mon: instance A (CNT_W=16, MIN=5, TIMEOUT=50) and instance B (CNT_W=4, MIN=0),
// each checked every cycle against a per-cycle behavioural model plus literal expectations.
module tb_rst_mon;

  localparam int unsigned SInRst = 0;
  localparam int unsigned SRun   = 1;
  localparam int unsigned SErr   = 2;

`ifdef RST_MON_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  typedef struct packed {
    int unsigned st;
    int unsigned len;
    int unsigned rlen;
    int unsigned run;
    int unsigned cnt;
    bit          pulse;
    bit          es;
    bit          et;
    bit          d1;
    bit          d2;
  } model_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses_a = 0;
  model_t ma, mb;

  always #5 clk = ~clk;

  rst_mon_if #(.CNT_W(16)) ifa ();
  rst_mon_if #(.CNT_W(4))  ifb ();

  rst_mon #(.MIN_RST_CYCLES(5), .CNT_W(16), .TIMEOUT_CYCLES(50)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_a),
    .mon_if (ifa)
  );

  rst_mon #(.MIN_RST_CYCLES(0), .CNT_W(4), .TIMEOUT_CYCLES(1000)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_b),
    .mon_if (ifb)
  );

  function automatic model_t m_reset();
    model_t m;
    m = '0;
    m.st = SInRst;
    return m;
  endfunction

  // One rising edge: obs_s is the observed reset as sampled two edges earlier.
  function automatic model_t m_step(input model_t mi, input bit obs, input int unsigned cmax,
                                    input int unsigned minc, input int unsigned tmo);
    model_t m;
    bit     s;
    m = mi;
    s = m.d2;
    m.d2 = m.d1;
    m.d1 = obs;
    m.pulse = 1'b0;
    if (m.st == SInRst) begin
      if (TmoEn && m.len >= tmo) begin
        m.st = SErr;
        m.et = 1'b1;
      end else if (!s) begin
        m.len = (m.len < cmax) ? m.len + 1 : cmax;
      end else begin
        m.rlen = m.len;
        if (m.len >= minc) begin
          m.st = SRun;
          m.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
          m.run = 0;
          m.pulse = 1'b1;
        end else begin
          m.st = SErr;
          m.es = 1'b1;
        end
      end
    end else if (m.st == SRun) begin
      if (s) begin
        m.run = (m.run < cmax) ? m.run + 1 : cmax;
      end else begin
        m.st = SInRst;
        m.len = 1;
      end
    end
    return m;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] len, input logic [31:0] run,
                     input logic [31:0] cnt, input logic p, input logic ir, input logic es,
                     input logic et, input model_t m);
    n_tests++;
    if (len !== m.rlen || run !== m.run || cnt !== m.cnt || p !== m.pulse ||
        ir !== (m.st == SInRst) || es !== m.es || et !== m.et) begin
      n_fail++;
      $display("FAIL %s @%0t: got len=%0d run=%0d cnt=%0d pulse=%b in_rst=%b short=%b tmo=%b; want len=%0d run=%0d cnt=%0d pulse=%b in_rst=%b short=%b tmo=%b",
               nm, $time, len, run, cnt, p, ir, es, et, m.rlen, m.run, m.cnt, m.pulse,
               (m.st == SInRst), m.es, m.et);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  initial begin
    ma = m_reset();
    forever begin
      @(posedge clk or negedge rst_a);
      if (!rst_a) ma = m_reset();
      else ma = m_step(ma, ifa.obs_rst_ni, 32'd65535, 32'd5, 32'd50);
    end
  end

  initial begin
    mb = m_reset();
    forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) mb = m_reset();
      else mb = m_step(mb, ifb.obs_rst_ni, 32'd15, 32'd0, 32'd1000);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cmp("model_a", 32'(ifa.rst_len_o), 32'(ifa.run_cyc_o), 32'(ifa.rst_cnt_o),
          ifa.rel_pulse_o, ifa.in_rst_o, ifa.err_short_o, ifa.err_timeout_o, ma);
      cmp("model_b", 32'(ifb.rst_len_o), 32'(ifb.run_cyc_o), 32'(ifb.rst_cnt_o),
          ifb.rel_pulse_o, ifb.in_rst_o, ifb.err_short_o, ifb.err_timeout_o, mb);
      if (ifa.rel_pulse_o === 1'b1) pulses_a++;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no end of stimulus, want end within 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic seq_a();
    ifa.obs_rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_reset_in_rst", 32'(ifa.in_rst_o), 32'd1);
    chk("a_reset_cnt", 32'(ifa.rst_cnt_o), 32'd0);
    rst_a = 1'b1;
    // Power-up assertion: 6 low edges plus 2 sync edges -> length 8.
    repeat (6) @(negedge clk);
    ifa.obs_rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    chk("a_first_cnt", 32'(ifa.rst_cnt_o), 32'd1);
    chk("a_first_len", 32'(ifa.rst_len_o), 32'd8);
    chk("a_first_run", 32'(ifa.run_cyc_o), 32'd17);
    chk("a_first_pulses", 32'(pulses_a), 32'd1);
    chk("a_first_in_rst", 32'(ifa.in_rst_o), 32'd0);
    // Ten-cycle assertion.
    ifa.obs_rst_ni = 1'b0;
    repeat (10) @(negedge clk);
    ifa.obs_rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    chk("a_ten_len", 32'(ifa.rst_len_o), 32'd10);
    chk("a_ten_cnt", 32'(ifa.rst_cnt_o), 32'd2);
    chk("a_ten_pulses", 32'(pulses_a), 32'd2);
    chk("a_ten_run", 32'(ifa.run_cyc_o), 32'd7);
    // Three-cycle assertion -> short error, frozen counters.
    ifa.obs_rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    ifa.obs_rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    chk("a_short_flag", 32'(ifa.err_short_o), 32'd1);
    chk("a_short_len", 32'(ifa.rst_len_o), 32'd3);
    chk("a_short_run", 32'(ifa.run_cyc_o), 32'd9);
    chk("a_short_cnt", 32'(ifa.rst_cnt_o), 32'd2);
    chk("a_short_pulses", 32'(pulses_a), 32'd2);
    #3 rst_a = 1'b0;
    ifa.obs_rst_ni = 1'b0;
    #1;
    chk("a_clr_short", 32'(ifa.err_short_o), 32'd0);
    chk("a_clr_cnt", 32'(ifa.rst_cnt_o), 32'd0);
    chk("a_clr_in_rst", 32'(ifa.in_rst_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    // Reach RUN, then abort with rst_ni part-way through an observed assertion.
    repeat (6) @(negedge clk);
    ifa.obs_rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    ifa.obs_rst_ni = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_mid_cnt_before", 32'(ifa.rst_cnt_o), 32'd1);
    chk("a_mid_in_rst_before", 32'(ifa.in_rst_o), 32'd1);
    #3 rst_a = 1'b0;
    #1;
    chk("a_abort_cnt", 32'(ifa.rst_cnt_o), 32'd0);
    chk("a_abort_len", 32'(ifa.rst_len_o), 32'd0);
    chk("a_abort_run", 32'(ifa.run_cyc_o), 32'd0);
    chk("a_abort_in_rst", 32'(ifa.in_rst_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    // Sixty-cycle assertion: timeout at 50 when enabled, else a valid length of 60.
    repeat (6) @(negedge clk);
    ifa.obs_rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    pulses_a = 0;
    ifa.obs_rst_ni = 1'b0;
    repeat (60) @(negedge clk);
    ifa.obs_rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    if (TmoEn) begin
      chk("a_long_tmo", 32'(ifa.err_timeout_o), 32'd1);
      chk("a_long_pulses", 32'(pulses_a), 32'd0);
      chk("a_long_cnt", 32'(ifa.rst_cnt_o), 32'd1);
      chk("a_long_len", 32'(ifa.rst_len_o), 32'd8);
    end else begin
      chk("a_long_tmo", 32'(ifa.err_timeout_o), 32'd0);
      chk("a_long_pulses", 32'(pulses_a), 32'd1);
      chk("a_long_cnt", 32'(ifa.rst_cnt_o), 32'd2);
      chk("a_long_len", 32'(ifa.rst_len_o), 32'd60);
    end
    // Observed reset already released when rst_ni lifts: only 2 counted cycles -> short.
    #3 rst_a = 1'b0;
    ifa.obs_rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (6) @(negedge clk);
    chk("a_pwrup_short", 32'(ifa.err_short_o), 32'd1);
    chk("a_pwrup_len", 32'(ifa.rst_len_o), 32'd2);
    chk("a_pwrup_cnt", 32'(ifa.rst_cnt_o), 32'd0);
  endtask

  task automatic seq_b();
    ifb.obs_rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
    chk("b_pwrup_short", 32'(ifb.err_short_o), 32'd0);
    chk("b_pwrup_cnt", 32'(ifb.rst_cnt_o), 32'd1);
    chk("b_pwrup_len", 32'(ifb.rst_len_o), 32'd2);
    for (int i = 0; i < 300; i++) begin
      ifb.obs_rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      ifb.obs_rst_ni = 1'b1;
      repeat (20) @(negedge clk);
    end
    chk("b_sat_cnt", 32'(ifb.rst_cnt_o), 32'd255);
    chk("b_sat_run", 32'(ifb.run_cyc_o), 32'd15);
    chk("b_sat_len", 32'(ifb.rst_len_o), 32'd2);
    ifb.obs_rst_ni = 1'b0;
    repeat (20) @(negedge clk);
    ifb.obs_rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    chk("b_len_sat", 32'(ifb.rst_len_o), 32'd15);
    ifb.obs_rst_ni = 1'b0;
    @(negedge clk);
    ifb.obs_rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    chk("b_one_len", 32'(ifb.rst_len_o), 32'd1);
    chk("b_one_short", 32'(ifb.err_short_o), 32'd0);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
